// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate port among NUM_REQ managers.
// Address phase is combinational; responses are routed back in grant order via an index FIFO.
module obi_rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned OBI_AW  = 32,
    parameter int unsigned OBI_DW  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         m_req_i,
    output logic [NUM_REQ-1:0]         m_gnt_o,
    input  logic [NUM_REQ*OBI_AW-1:0]  m_addr_i,
    input  logic [NUM_REQ-1:0]         m_we_i,
    input  logic [NUM_REQ*OBI_DW/8-1:0] m_be_i,
    input  logic [NUM_REQ*OBI_DW-1:0]  m_wdata_i,
    output logic [NUM_REQ-1:0]         m_rvalid_o,
    input  logic [NUM_REQ-1:0]         m_rready_i,
    output logic [OBI_DW-1:0]          m_rdata_o,
    output logic                       m_err_o,
    output logic                       s_req_o,
    input  logic                       s_gnt_i,
    output logic [OBI_AW-1:0]          s_addr_o,
    output logic                       s_we_o,
    output logic [OBI_DW/8-1:0]        s_be_o,
    output logic [OBI_DW-1:0]          s_wdata_o,
    input  logic                       s_rvalid_i,
    output logic                       s_rready_o,
    input  logic [OBI_DW-1:0]          s_rdata_i,
    input  logic                       s_err_i,
    output logic                       protocol_err_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned BE_W  = OBI_DW / 8;

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] sel_q;
    logic             lock_q;
    logic [IDX_W-1:0] arb_sel;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] fifo_q [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             perr_q;
    logic             full;
    logic             busy;
    logic             push;
    logic             pop;

    // First requester at or after rr_ptr_q, with wrap-around.
    always_comb begin
        int unsigned idx;
        logic        found;
        arb_sel = rr_ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && m_req_i[IDX_W'(idx)]) begin
                found   = 1'b1;
                arb_sel = IDX_W'(idx);
            end
        end
    end

    assign sel  = lock_q ? sel_q : arb_sel;
    assign full = (count_q == CNT_W'(MAX_OUT));
    assign busy = (count_q != '0);
    assign head = fifo_q[rd_ptr_q];

    assign s_req_o   = (|m_req_i) & ~full;
    assign s_addr_o  = m_addr_i[sel*OBI_AW +: OBI_AW];
    assign s_we_o    = m_we_i[sel];
    assign s_be_o    = m_be_i[sel*BE_W +: BE_W];
    assign s_wdata_o = m_wdata_i[sel*OBI_DW +: OBI_DW];

    always_comb begin
        m_gnt_o      = '0;
        m_gnt_o[sel] = s_gnt_i & s_req_o;
    end

    always_comb begin
        m_rvalid_o       = '0;
        m_rvalid_o[head] = s_rvalid_i & busy;
    end

    // With nothing outstanding, stray responses are accepted and dropped.
    assign s_rready_o     = busy ? m_rready_i[head] : 1'b1;
    assign m_rdata_o      = s_rdata_i;
    assign m_err_o        = s_err_i;
    assign protocol_err_o = perr_q;

    assign push = s_req_o & s_gnt_i;
    assign pop  = s_rvalid_i & s_rready_o & busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            sel_q    <= '0;
            lock_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            if (push) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= (32'(sel) == NUM_REQ - 1) ? '0 : sel + IDX_W'(1);
                wr_ptr_q <= (32'(wr_ptr_q) == MAX_OUT - 1) ? '0 : wr_ptr_q + PTR_W'(1);
            end else if (lock_q && !m_req_i[sel_q]) begin
                lock_q <= 1'b0;
            end else if (s_req_o) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end
            if (pop) begin
                rd_ptr_q <= (32'(rd_ptr_q) == MAX_OUT - 1) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (s_rvalid_i && !busy) begin
                perr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Randomized bench for obi_rr_arbiter: transaction-level reference model plus
// a response scoreboard fed at grant time and drained by an independent monitor.
module tb_obi_rr_arbiter;

    localparam int NUM_REQ = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_OUT = 4;
    localparam int BEW     = DW / 8;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     m_req_i;
    logic [NUM_REQ-1:0]     m_gnt_o;
    logic [NUM_REQ*AW-1:0]  m_addr_i;
    logic [NUM_REQ-1:0]     m_we_i;
    logic [NUM_REQ*BEW-1:0] m_be_i;
    logic [NUM_REQ*DW-1:0]  m_wdata_i;
    logic [NUM_REQ-1:0]     m_rvalid_o;
    logic [NUM_REQ-1:0]     m_rready_i;
    logic [DW-1:0]          m_rdata_o;
    logic                   m_err_o;
    logic                   s_req_o;
    logic                   s_gnt_i;
    logic [AW-1:0]          s_addr_o;
    logic                   s_we_o;
    logic [BEW-1:0]         s_be_o;
    logic [DW-1:0]          s_wdata_o;
    logic                   s_rvalid_i;
    logic                   s_rready_o;
    logic [DW-1:0]          s_rdata_i;
    logic                   s_err_i;
    logic                   protocol_err_o;

    obi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .OBI_AW  (AW),
        .OBI_DW  (DW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .m_req_i        (m_req_i),
        .m_gnt_o        (m_gnt_o),
        .m_addr_i       (m_addr_i),
        .m_we_i         (m_we_i),
        .m_be_i         (m_be_i),
        .m_wdata_i      (m_wdata_i),
        .m_rvalid_o     (m_rvalid_o),
        .m_rready_i     (m_rready_i),
        .m_rdata_o      (m_rdata_o),
        .m_err_o        (m_err_o),
        .s_req_o        (s_req_o),
        .s_gnt_i        (s_gnt_i),
        .s_addr_o       (s_addr_o),
        .s_we_o         (s_we_o),
        .s_be_o         (s_be_o),
        .s_wdata_o      (s_wdata_o),
        .s_rvalid_i     (s_rvalid_i),
        .s_rready_o     (s_rready_o),
        .s_rdata_i      (s_rdata_i),
        .s_err_i        (s_err_i),
        .protocol_err_o (protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         mgr;
        logic [31:0] rdata;
        logic       err;
    } rsp_t;

    // Reference model: who was granted last, who holds a stalled address phase,
    // and the managers owed a response in grant order.
    int   last_gnt;
    int   locked;
    int   outst[$];
    rsp_t sb_q[$];
    rsp_t sub_q[$];
    bit   perr_exp;
    bit   got_gnt[NUM_REQ];
    bit   rsp_hs;
    bit   chk_en;
    int   vectors;
    int   miscompares;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic reset_model();
        last_gnt = NUM_REQ - 1;
        locked   = -1;
        outst.delete();
        sb_q.delete();
        sub_q.delete();
        perr_exp = 1'b0;
        rsp_hs   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) got_gnt[k] = 1'b0;
    endtask

    // Address phase, routing and error flag against the model; advances the model.
    always @(negedge clk) begin : addr_monitor
        int                 sel;
        bit                 ereq;
        bit                 had_out;
        logic [NUM_REQ-1:0] egnt;
        logic [NUM_REQ-1:0] ervalid;
        logic               erready;
        rsp_t               r;
        if (chk_en) begin
            had_out = outst.size() > 0;
            ereq    = (|m_req_i) && (outst.size() < MAX_OUT);
            sel     = -1;
            if (locked >= 0) begin
                sel = locked;
            end else begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    int k;
                    k = (last_gnt + i) % NUM_REQ;
                    if (sel < 0 && m_req_i[k]) sel = k;
                end
            end
            check("s_req", 128'(s_req_o), 128'(ereq));
            if (ereq) begin
                check("addr_phase", {s_addr_o, s_we_o, s_be_o, s_wdata_o},
                      {m_addr_i[sel*AW +: AW], m_we_i[sel], m_be_i[sel*BEW +: BEW],
                       m_wdata_i[sel*DW +: DW]});
            end
            egnt = (ereq && s_gnt_i) ? (NUM_REQ'(1) << sel) : '0;
            check("m_gnt", 128'(m_gnt_o), 128'(egnt));
            ervalid = (had_out && s_rvalid_i) ? (NUM_REQ'(1) << outst[0]) : '0;
            erready = had_out ? m_rready_i[outst[0]] : 1'b1;
            check("m_rvalid", 128'(m_rvalid_o), 128'(ervalid));
            check("s_rready", 128'(s_rready_o), 128'(erready));
            check("protocol_err", 128'(protocol_err_o), 128'(perr_exp));

            if (s_rvalid_i && erready) begin
                if (had_out) void'(outst.pop_front());
                else perr_exp = 1'b1;
            end
            if (s_rvalid_i && s_rready_o && sub_q.size() > 0) rsp_hs = 1'b1;
            if (ereq && s_gnt_i) begin
                got_gnt[sel] = 1'b1;
                last_gnt     = sel;
                locked       = -1;
                outst.push_back(sel);
                r.mgr   = sel;
                r.rdata = $urandom;
                r.err   = ($urandom_range(7) == 0);
                sub_q.push_back(r);
                sb_q.push_back(r);
            end else if (ereq) begin
                locked = sel;
            end
        end
    end

    // Response scoreboard: every delivered response must be the oldest expected one.
    always @(negedge clk) begin : rsp_monitor
        rsp_t e;
        if (chk_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_rvalid_o[k] && m_rready_i[k]) begin
                    if (sb_q.size() == 0) begin
                        check("rsp_unexpected", 128'(k), 128'(-1));
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_mgr", 128'(k), 128'(e.mgr));
                        check("rsp_data", {m_rdata_o, m_err_o}, {e.rdata, e.err});
                    end
                end
            end
        end
    end

    // Managers hold each request until granted; the subordinate answers in order.
    task automatic drive_cycle(int req_pct, int rsp_pct);
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (got_gnt[k]) m_req_i[k] = 1'b0;
            got_gnt[k] = 1'b0;
            if (!m_req_i[k] && $urandom_range(99) < req_pct) begin
                m_req_i[k]              = 1'b1;
                m_addr_i[k*AW +: AW]    = $urandom;
                m_we_i[k]               = $urandom_range(1) == 1;
                m_be_i[k*BEW +: BEW]    = BEW'($urandom);
                m_wdata_i[k*DW +: DW]   = $urandom;
            end
        end
        m_rready_i = NUM_REQ'($urandom);
        s_gnt_i    = $urandom_range(99) < 70;
        if (rsp_hs) begin
            void'(sub_q.pop_front());
            s_rvalid_i = 1'b0;
            rsp_hs     = 1'b0;
        end
        if (!s_rvalid_i && sub_q.size() > 0 && $urandom_range(99) < rsp_pct) s_rvalid_i = 1'b1;
        s_rdata_i = s_rvalid_i ? sub_q[0].rdata : $urandom;
        s_err_i   = s_rvalid_i ? sub_q[0].err : 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst         = 1'b1;
        m_req_i     = '0;
        m_addr_i    = '0;
        m_we_i      = '0;
        m_be_i      = '0;
        m_wdata_i   = '0;
        m_rready_i  = '0;
        s_gnt_i     = 1'b0;
        s_rvalid_i  = 1'b0;
        s_rdata_i   = '0;
        s_err_i     = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 128'(m_gnt_o), 128'(0));
        check("rst_rvalid", 128'(m_rvalid_o), 128'(0));
        check("rst_s_req", 128'(s_req_o), 128'(0));
        check("rst_s_rready", 128'(s_rready_o), 128'(1));
        check("rst_perr", 128'(protocol_err_o), 128'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        repeat (1500) drive_cycle(60, 60);
        // Slow subordinate keeps the outstanding window full.
        repeat (1500) drive_cycle(80, 10);
        for (int c = 0; c < 400 && (sub_q.size() > 0 || (|m_req_i) || s_rvalid_i); c++) begin
            drive_cycle(0, 100);
        end
        @(posedge clk);
        #1;
        m_req_i    = '0;
        s_rvalid_i = 1'b0;
        @(negedge clk);
        check("drain_sb", 128'(sb_q.size()), 128'(0));
        check("drain_outst", 128'(outst.size()), 128'(0));

        // Stray response with nothing outstanding.
        @(posedge clk);
        #1;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hDEADBEEF;
        m_rready_i = '0;
        @(negedge clk);
        check("spur_rready", 128'(s_rready_o), 128'(1));
        check("spur_rvalid", 128'(m_rvalid_o), 128'(0));
        @(posedge clk);
        #1;
        s_rvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("spur_sticky", 128'(protocol_err_o), 128'(1));
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        check("perr_cleared", 128'(protocol_err_o), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
